// File: rtl/ro_meas_ctrl_if.sv
// Control/result bundle of the ring-oscillator measurement controller.
interface ro_meas_ctrl_if #(
  parameter int WIN_W = 16,
  parameter int CNT_W = 16
);
  logic             start;
  logic             abort;
  logic [WIN_W-1:0] window_len;
  logic             busy;
  logic             done;
  logic [CNT_W-1:0] count;
  logic             overflow;

  modport master (
    output start, abort, window_len,
    input  busy, done, count, overflow
  );

  modport slave (
    input  start, abort, window_len,
    output busy, done, count, overflow
  );
endinterface

// File: rtl/ro_meas_ctrl.sv
// Ring-oscillator measurement controller: gates the oscillator, counts divider-tap edges over a window.
// Define RO_MEAS_AVG_EN to average four back-to-back windows per start.
module ro_meas_ctrl #(
  parameter int WIN_W       = 16,
  parameter int CNT_W       = 16,
  parameter int SYNC_STAGES = 2,
  parameter int WARMUP      = 4
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           ro_tick,
  output logic           ro_en,
  ro_meas_ctrl_if.slave  bus
);

  typedef enum logic [2:0] {S_IDLE, S_WARM, S_MEAS, S_DRAIN, S_DONE} state_t;

  localparam logic [WIN_W-1:0] L_ONE      = WIN_W'(1);
  localparam logic [WIN_W-1:0] WARM_LAST  = WIN_W'(WARMUP - 1);
  localparam logic [WIN_W-1:0] DRAIN_LAST = WIN_W'(SYNC_STAGES - 1);

  state_t                 r_state, w_state_nxt;
  logic [WIN_W-1:0]       r_len, r_tmr;
  logic [SYNC_STAGES-1:0] r_sync;
  logic                   r_prev;
  logic [CNT_W-1:0]       r_edge, r_count;
  logic                   r_sat, r_ovf, r_done;
  logic                   w_rise, w_tmr_clr, w_win_end;
  logic [CNT_W-1:0]       w_edge_nxt;
  logic                   w_sat_nxt;
`ifdef RO_MEAS_AVG_EN
  logic [CNT_W+1:0]       r_acc;
  logic [1:0]             r_win;
`endif

  assign w_rise    = r_sync[SYNC_STAGES-1] & ~r_prev;
  assign w_win_end = (r_state == S_MEAS) && (r_tmr == r_len - L_ONE);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_sync <= '0;
      r_prev <= 1'b0;
    end else begin
      r_sync <= {r_sync[SYNC_STAGES-2:0], ro_tick};
      r_prev <= r_sync[SYNC_STAGES-1];
    end
  end

  always_comb begin
    w_edge_nxt = r_edge;
    w_sat_nxt  = r_sat;
    if (r_state == S_MEAS && w_rise) begin
      if (r_edge == '1) w_sat_nxt  = 1'b1;
      else              w_edge_nxt = r_edge + CNT_W'(1);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_state <= S_IDLE;
    else     r_state <= w_state_nxt;
  end

  // DRAIN holds SYNC_STAGES cycles; the DONE cycle completes the settle period and the
  // registered done/count appear on the exit edge, when the FSM is already back in IDLE.
  always_comb begin
    w_state_nxt = r_state;
    w_tmr_clr   = 1'b0;
    case (r_state)
      S_IDLE: if (bus.start) begin
        w_state_nxt = S_WARM;
        w_tmr_clr   = 1'b1;
      end
      S_WARM: if (r_tmr == WARM_LAST) begin
        w_state_nxt = (r_len == '0) ? S_DRAIN : S_MEAS;
        w_tmr_clr   = 1'b1;
      end
      S_MEAS: if (w_win_end) begin
        w_tmr_clr = 1'b1;
`ifdef RO_MEAS_AVG_EN
        if (r_win == 2'd3) w_state_nxt = S_DRAIN;
`else
        w_state_nxt = S_DRAIN;
`endif
      end
      S_DRAIN: if (r_tmr == DRAIN_LAST) begin
        w_state_nxt = S_DONE;
        w_tmr_clr   = 1'b1;
      end
      S_DONE:  w_state_nxt = S_IDLE;
      default: w_state_nxt = S_IDLE;
    endcase
    if (bus.abort && r_state != S_IDLE) w_state_nxt = S_IDLE;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst)            r_tmr <= '0;
    else if (w_tmr_clr) r_tmr <= '0;
    else                r_tmr <= r_tmr + L_ONE;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_len   <= '0;
      r_edge  <= '0;
      r_sat   <= 1'b0;
      r_count <= '0;
      r_ovf   <= 1'b0;
      r_done  <= 1'b0;
`ifdef RO_MEAS_AVG_EN
      r_acc   <= '0;
      r_win   <= '0;
`endif
    end else begin
      r_done <= 1'b0;
      if (r_state == S_IDLE && bus.start) begin
        r_len  <= bus.window_len;
        r_edge <= '0;
        r_sat  <= 1'b0;
`ifdef RO_MEAS_AVG_EN
        r_acc  <= '0;
        r_win  <= '0;
`endif
      end else if (r_state == S_MEAS) begin
        r_sat <= w_sat_nxt;
`ifdef RO_MEAS_AVG_EN
        if (w_win_end) begin
          r_acc  <= r_acc + {2'b00, w_edge_nxt};
          r_edge <= '0;
          r_win  <= r_win + 2'd1;
        end else begin
          r_edge <= w_edge_nxt;
        end
`else
        r_edge <= w_edge_nxt;
`endif
      end
      if (r_state == S_DONE && !bus.abort) begin
        r_done  <= 1'b1;
        r_ovf   <= r_sat;
`ifdef RO_MEAS_AVG_EN
        r_count <= r_acc[CNT_W+1:2];
`else
        r_count <= r_edge;
`endif
      end
    end
  end

  assign ro_en        = (r_state == S_WARM) || (r_state == S_MEAS);
  assign bus.busy     = (r_state != S_IDLE);
  assign bus.done     = r_done;
  assign bus.count    = r_count;
  assign bus.overflow = r_ovf;

endmodule

// File: tb/tb_ro_meas_ctrl.sv
// Scoreboard bench for ro_meas_ctrl: expected results queued at start, checked when done pulses.
module tb_ro_meas_ctrl;
  localparam int W = 4;
  localparam int S = 2;
`ifdef RO_MEAS_AVG_EN
  localparam int R = 4;
`else
  localparam int R = 1;
`endif

  typedef struct {
    int cyc;
    int cnt;
    int ovf;
  } exp_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  int cyc = 0;
  int checks = 0;
  int fails = 0;
  exp_t q_a[$];
  exp_t q_b[$];

  ro_meas_ctrl_if #(.WIN_W(16), .CNT_W(16)) bus_a ();
  ro_meas_ctrl_if #(.WIN_W(16), .CNT_W(4))  bus_b ();

  logic en_a, en_b;
  logic tick_a = 1'b0, tick_b = 1'b0;
  logic [1:0] ph_a = '0, ph_b = '0;

  ro_meas_ctrl #(.WIN_W(16), .CNT_W(16), .SYNC_STAGES(S), .WARMUP(W)) dut_a (
    .clk(clk), .rst(rst), .ro_tick(tick_a), .ro_en(en_a), .bus(bus_a));
  ro_meas_ctrl #(.WIN_W(16), .CNT_W(4), .SYNC_STAGES(S), .WARMUP(W)) dut_b (
    .clk(clk), .rst(rst), .ro_tick(tick_b), .ro_en(en_b), .bus(bus_b));

  // Oscillator model: clk/4 square wave (2 high, 2 low) that runs only while enabled.
  always @(negedge clk) begin
    if (en_a) begin
      ph_a   <= ph_a + 2'd1;
      tick_a <= (ph_a == 2'd1) || (ph_a == 2'd2);
    end else begin
      ph_a   <= '0;
      tick_a <= 1'b0;
    end
    if (en_b) begin
      ph_b   <= ph_b + 2'd1;
      tick_b <= (ph_b == 2'd1) || (ph_b == 2'd2);
    end else begin
      ph_b   <= '0;
      tick_b <= 1'b0;
    end
  end

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      fails++;
      $display("FAIL %s got=%0d want=%0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  always @(posedge clk) begin
    exp_t e;
    #1;
    if (bus_a.done) begin
      if (q_a.size() == 0) chk("a_unexpected_done", 1, 0);
      else begin
        e = q_a.pop_front();
        chk("a_done_cycle", cyc, e.cyc);
        chk("a_count", int'(bus_a.count), e.cnt);
        chk("a_overflow", int'(bus_a.overflow), e.ovf);
      end
    end
    if (bus_b.done) begin
      if (q_b.size() == 0) chk("b_unexpected_done", 1, 0);
      else begin
        e = q_b.pop_front();
        chk("b_done_cycle", cyc, e.cyc);
        chk("b_count", int'(bus_b.count), e.cnt);
        chk("b_overflow", int'(bus_b.overflow), e.ovf);
      end
    end
  end

  task automatic wait_done_a(input int limit);
    int k;
    for (k = 0; k < limit; k++) begin
      if (bus_a.done) break;
      @(negedge clk);
    end
    if (!bus_a.done) chk("a_done_timeout", 0, 1);
  endtask

  initial begin
    int acc, acc2, en_cnt;
    bus_a.start = 1'b0; bus_a.abort = 1'b0; bus_a.window_len = '0;
    bus_b.start = 1'b0; bus_b.abort = 1'b0; bus_b.window_len = '0;

    repeat (3) @(negedge clk);
    chk("rst_ro_en", int'(en_a), 0);
    chk("rst_busy", int'(bus_a.busy), 0);
    chk("rst_done", int'(bus_a.done), 0);
    chk("rst_count", int'(bus_a.count), 0);
    chk("rst_overflow", int'(bus_a.overflow), 0);
    rst = 1'b0;
    @(negedge clk);

    // N=100 on both; CNT_W=4 instance saturates
    bus_a.window_len = 16'd100; bus_a.start = 1'b1;
    bus_b.window_len = 16'd100; bus_b.start = 1'b1;
    acc = cyc + 1;
    q_a.push_back('{acc + W + 100*R + S + 1, 25, 0});
    q_b.push_back('{acc + W + 100*R + S + 1, 15, 1});
    @(negedge clk);
    bus_a.start = 1'b0; bus_b.start = 1'b0;
    chk("busy_after_start", int'(bus_a.busy), 1);
    en_cnt = 0;
    for (int k = 0; k < 1000; k++) begin
      if (en_a) en_cnt++;
      if (bus_a.done) break;
      @(negedge clk);
    end
    if (!bus_a.done) chk("a_done_timeout", 0, 1);
    chk("ro_en_cycles", en_cnt, W + 100*R);
    chk("busy_in_done_cycle", int'(bus_a.busy), 0);
    @(negedge clk);

    // zero-length window: oscillator only during warm-up
    bus_a.window_len = 16'd0; bus_a.start = 1'b1;
    acc = cyc + 1;
    q_a.push_back('{acc + W + S + 1, 0, 0});
    for (int i = 0; i <= W; i++) begin
      @(negedge clk);
      bus_a.start = 1'b0;
      chk($sformatf("zero_win_ro_en_%0d", i), int'(en_a), (i < W) ? 1 : 0);
    end
    wait_done_a(100);
    @(negedge clk);

    // start while busy is ignored; start in the done cycle begins a new run
    bus_a.window_len = 16'd100; bus_a.start = 1'b1;
    acc = cyc + 1;
    q_a.push_back('{acc + W + 100*R + S + 1, 25, 0});
    @(negedge clk);
    bus_a.start = 1'b0;
    repeat (W + 19) @(negedge clk);
    bus_a.start = 1'b1;
    @(negedge clk);
    bus_a.start = 1'b0;
    wait_done_a(1000);
    bus_a.start = 1'b1;
    acc2 = cyc + 1;
    @(negedge clk);
    bus_a.start = 1'b0;
    chk("restart_in_done_cycle_busy", int'(bus_a.busy), 1);

    // abort 10 cycles into MEAS: no done, previous result kept
    repeat (W + 9) @(negedge clk);
    chk("pre_abort_cycle", cyc, acc2 + W + 9);
    bus_a.abort = 1'b1;
    @(negedge clk);
    bus_a.abort = 1'b0;
    chk("abort_ro_en", int'(en_a), 0);
    chk("abort_busy", int'(bus_a.busy), 0);
    chk("abort_count_kept", int'(bus_a.count), 25);
    repeat (120) @(negedge clk);
    chk("abort_count_still", int'(bus_a.count), 25);

    // start and abort together in IDLE: start wins
    bus_a.window_len = 16'd8; bus_a.start = 1'b1; bus_a.abort = 1'b1;
    acc = cyc + 1;
    q_a.push_back('{acc + W + 8*R + S + 1, 2, 0});
    @(negedge clk);
    bus_a.start = 1'b0; bus_a.abort = 1'b0;
    chk("start_abort_busy", int'(bus_a.busy), 1);
    wait_done_a(200);
    @(negedge clk);

    // asynchronous reset mid-MEAS
    bus_a.window_len = 16'd100; bus_a.start = 1'b1;
    @(negedge clk);
    bus_a.start = 1'b0;
    repeat (W + 30) @(negedge clk);
    chk("pre_reset_ro_en", int'(en_a), 1);
    #2 rst = 1'b1;
    #1;
    chk("async_rst_ro_en", int'(en_a), 0);
    chk("async_rst_busy", int'(bus_a.busy), 0);
    chk("async_rst_count_a", int'(bus_a.count), 0);
    chk("async_rst_count_b", int'(bus_b.count), 0);
    chk("async_rst_overflow_b", int'(bus_b.overflow), 0);
    @(negedge clk);
    rst = 1'b0;

    repeat (20) @(negedge clk);
    chk("a_queue_empty", q_a.size(), 0);
    chk("b_queue_empty", q_b.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, fails);
    $finish;
  end

endmodule
